// File: rtl/mariam_cnt_pkg.sv
// Shared constants for the mariam up/down counter family.
// Optional feature macro used by the counter: MARIAM_CNT_PRESCALE_EN.
package mariam_cnt_pkg;

  // Direction encoding on up_down
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  // Boundary behaviour encoding on sat_mode
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Legal configuration ranges
  localparam int CNT_WIDTH_MIN = 2;
  localparam int CNT_WIDTH_MAX = 16;
  localparam int PRESCALE_MIN  = 2;
  localparam int PRESCALE_MAX  = 256;

endpackage

// File: rtl/mariam_cnt_prescaler.sv
// Enabled-cycle prescaler: step_ok fires on the enabled cycle that closes
// each group of PRESCALE enabled cycles. Only built with MARIAM_CNT_PRESCALE_EN.
module mariam_cnt_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic step_ok
);

  localparam int            PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0] r_ps;

  // Phase counter: clear wins, holds while disabled, rolls over at LAST
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_ps <= '0;
    else if (clr)      r_ps <= '0;
    else if (en)       r_ps <= (r_ps == LAST) ? '0 : r_ps + ONE;
  end

  assign step_ok = en & (r_ps == LAST);

endmodule

// File: rtl/mariam_mod_updown_counter.sv
// Programmable-modulus up/down counter with wrap/saturate, load, tc pulse
// and sticky overflow. Optional prescaler under MARIAM_CNT_PRESCALE_EN.
module mariam_mod_updown_counter
  import mariam_cnt_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             ovf,
  output logic [WIDTH-1:0] io_oeb
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Reject out-of-range configurations at elaboration
  if (WIDTH < CNT_WIDTH_MIN || WIDTH > CNT_WIDTH_MAX) begin : g_bad_width
    $error("mariam_mod_updown_counter: WIDTH out of range");
  end
  if (PRESCALE < PRESCALE_MIN || PRESCALE > PRESCALE_MAX) begin : g_bad_prescale
    $error("mariam_mod_updown_counter: PRESCALE out of range");
  end

  logic [WIDTH-1:0] r_cnt;
  logic             r_tc;
  logic             r_ovf;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_load_clip;
  logic             w_bnd;
  logic             w_step_ok;
  logic             w_step;

`ifdef MARIAM_CNT_PRESCALE_EN
  mariam_cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_ps (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .clr      (load),
    .step_ok  (w_step_ok)
  );
`else
  assign w_step_ok = 1'b1;
`endif

  // Load wins over step; a step needs enable and prescaler terminal
  assign w_step      = en & ~load & w_step_ok;
  assign w_load_clip = (load_val > limit) ? limit : load_val;

  // Next count for a step, flagging boundary events (>= covers a lowered limit)
  always_comb begin
    w_nxt = r_cnt;
    w_bnd = 1'b0;
    if (up_down == DIR_UP) begin
      if (r_cnt >= limit) begin
        w_bnd = 1'b1;
        w_nxt = (sat_mode == MODE_SAT) ? limit : '0;
      end else begin
        w_nxt = r_cnt + ONE;
      end
    end else begin
      if (r_cnt == '0) begin
        w_bnd = 1'b1;
        w_nxt = (sat_mode == MODE_SAT) ? '0 : limit;
      end else begin
        w_nxt = r_cnt - ONE;
      end
    end
  end

  // Count register and one-cycle terminal-count pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
    end else if (load) begin
      r_cnt <= w_load_clip;
      r_tc  <= 1'b0;
    end else if (w_step) begin
      r_cnt <= w_nxt;
      r_tc  <= w_bnd;
    end else begin
      r_tc  <= 1'b0;
    end
  end

  // Sticky overflow: a boundary event beats a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            r_ovf <= 1'b0;
    else if (w_step & w_bnd) r_ovf <= 1'b1;
    else if (ovf_clr)        r_ovf <= 1'b0;
  end

  assign counter = r_cnt;
  assign tc      = r_tc;
  assign ovf     = r_ovf;
  assign io_oeb  = '0;

endmodule

// File: tb/tb_mariam_mod_updown_counter.sv
// Directed bench for mariam_mod_updown_counter (WIDTH = 4, PRESCALE = 3).
// Prescaler vectors run instead of the base set when MARIAM_CNT_PRESCALE_EN is defined.
module tb_mariam_mod_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en, up_down, sat_mode, load, ovf_clr;
  logic [W-1:0] load_val, limit;
  logic [W-1:0] counter, io_oeb;
  logic         tc, ovf;

  int n_tot = 0;
  int n_bad = 0;

  // Prescaler vectors: en, load, load_val, expected counter after the edge
  int ps_en [13] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  int ps_ld [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  int ps_lv [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0};
  int ps_ex [13] = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 5, 5, 5, 6};

  // Base-set saturate-down expectations after the load
  int sd_cnt [4] = '{1, 0, 0, 0};
  int sd_tc  [4] = '{0, 0, 1, 1};

  mariam_mod_updown_counter #(.WIDTH(W), .PRESCALE(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .up_down  (up_down),
    .sat_mode (sat_mode),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .ovf_clr  (ovf_clr),
    .counter  (counter),
    .tc       (tc),
    .ovf      (ovf),
    .io_oeb   (io_oeb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; up_down = 1'b0; sat_mode = 1'b0;
    load = 1'b0; ovf_clr = 1'b0; load_val = '0; limit = '0;
    #12;
    chk("rst_cnt", 32'(counter), 0);
    chk("rst_tc",  32'(tc), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("oeb",     32'(io_oeb), 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

`ifdef MARIAM_CNT_PRESCALE_EN
    limit = 4'd15; up_down = 1'b0; sat_mode = 1'b0;
    for (int i = 0; i < 13; i++) begin
      en = ps_en[i][0]; load = ps_ld[i][0]; load_val = ps_lv[i][W-1:0];
      tick();
      chk($sformatf("ps_cnt%0d", i), 32'(counter), 32'(ps_ex[i]));
      chk($sformatf("ps_tc%0d", i),  32'(tc), 0);
    end
    load = 1'b0; en = 1'b0;
`else
    // Wrap up through limit 9
    limit = 4'd9; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("wrap_cnt%0d", i), 32'(counter), 32'(i % 10));
      chk($sformatf("wrap_tc%0d", i),  32'(tc), (i % 10 == 0) ? 1 : 0);
    end
    chk("wrap_ovf", 32'(ovf), 1);

    // Count on to 9, then async reset mid-cycle
    for (int i = 0; i < 7; i++) tick();
    chk("pre_rst_cnt", 32'(counter), 9);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cnt", 32'(counter), 0);
    chk("arst_tc",  32'(tc), 0);
    chk("arst_ovf", 32'(ovf), 0);
    @(negedge clk);
    reset_n = 1'b1;
    en = 1'b0;
    tick();

    // Saturate down from a loaded 2
    limit = 4'd5; sat_mode = 1'b1; up_down = 1'b1; load_val = 4'd2; load = 1'b1;
    tick();
    chk("sd_load", 32'(counter), 2);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("sd_cnt%0d", i), 32'(counter), 32'(sd_cnt[i]));
      chk($sformatf("sd_tc%0d", i),  32'(tc), 32'(sd_tc[i]));
    end
    chk("sd_ovf", 32'(ovf), 1);

    // Load beats step and clips to limit
    load = 1'b1; load_val = 4'd14; limit = 4'd10; up_down = 1'b0; sat_mode = 1'b0;
    tick();
    chk("ld_cnt", 32'(counter), 10);
    chk("ld_tc",  32'(tc), 0);

    // Clear collides with wrap: set wins; then clear alone
    load = 1'b0; ovf_clr = 1'b1;
    tick();
    chk("clr_wrap_cnt", 32'(counter), 0);
    chk("clr_wrap_tc",  32'(tc), 1);
    chk("clr_wrap_ovf", 32'(ovf), 1);
    en = 1'b0;
    tick();
    chk("clr_ovf",  32'(ovf), 0);
    chk("clr_tc",   32'(tc), 0);
    ovf_clr = 1'b0;

    // limit = 0: every step is a boundary
    limit = 4'd0; en = 1'b1;
    tick();
    chk("l0_up_cnt", 32'(counter), 0);
    chk("l0_up_tc",  32'(tc), 1);
    up_down = 1'b1;
    tick();
    chk("l0_dn_cnt", 32'(counter), 0);
    chk("l0_dn_tc",  32'(tc), 1);
    chk("l0_ovf",    32'(ovf), 1);

    // Saturate up holds at limit
    up_down = 1'b0; sat_mode = 1'b1; limit = 4'd3; load_val = 4'd3; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    chk("su_cnt", 32'(counter), 3);
    chk("su_tc",  32'(tc), 1);

    // Limit lowered below count: down decrements, up wraps / saturates
    limit = 4'd12; load_val = 4'd12; load = 1'b1; sat_mode = 1'b0;
    tick();
    load = 1'b0; limit = 4'd3; up_down = 1'b1;
    tick();
    chk("low_dn_cnt", 32'(counter), 11);
    chk("low_dn_tc",  32'(tc), 0);
    up_down = 1'b0;
    tick();
    chk("low_up_cnt", 32'(counter), 0);
    chk("low_up_tc",  32'(tc), 1);
    limit = 4'd12; load = 1'b1;
    tick();
    load = 1'b0; limit = 4'd3; sat_mode = 1'b1;
    tick();
    chk("low_sat_cnt", 32'(counter), 3);
    chk("low_sat_tc",  32'(tc), 1);

    // Enable low holds everything
    en = 1'b0;
    tick();
    chk("hold_cnt", 32'(counter), 3);
    chk("hold_tc",  32'(tc), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/mariam_mod_updown_counter.md
Name: mariam_mod_updown_counter

Overview:
- Parametrised successor to the team's 4-bit up/down counter.
- Adds:
  - configurable width
  - programmable modulus (runtime limit)
  - wrap or saturate mode
  - count enable and synchronous parallel load
  - one-cycle terminal-count pulse
  - sticky overflow flag
- Sits in the user area, driving IO pads directly; io_oeb is tied to output-enable.

Parameters:
- WIDTH, 8, counter, load and limit bit width (legal 2..16).
- PRESCALE, 4, enabled cycles per count step; only meaningful when MARIAM_CNT_PRESCALE_EN is defined (legal 2..256).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  count enable; no step when low.
- up_down  input  1  direction: 0 = up, 1 = down.
- sat_mode  input  1  boundary mode: 0 = wrap, 1 = saturate.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded on load.
- limit  input  WIDTH  top count value (modulus = limit+1).
- ovf_clr  input  1  clears sticky ovf.
- counter  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered).
- ovf  output  1  sticky boundary-hit flag.
- io_oeb  output  WIDTH  constant all-zero (pads driven as outputs).

Behaviour:
- Reset (reset_n low, asynchronous): counter = 0, tc = 0, ovf = 0, prescaler = 0. Outputs hold while reset_n is low; the first update occurs on the first rising clk after deassertion.
- Priority per cycle: load > step > hold.
- Load:
  - counter <= min(load_val, limit).
  - tc <= 0.
  - The load strobe takes effect regardless of en.
- Step: occurs when en = 1 and load = 0 (and the prescaler is at terminal, if compiled in).
- Up step:
  - If counter >= limit: wrap mode gives counter <= 0; saturate mode holds counter at limit. Either way this is a boundary event.
  - Else counter <= counter + 1.
- Down step:
  - If counter == 0: wrap mode gives counter <= limit; saturate mode holds counter at 0. Either way this is a boundary event.
  - Else counter <= counter - 1. If counter > limit (limit lowered mid-count), decrement normally.
- tc:
  - Asserts for exactly one cycle, in the same cycle counter shows the post-event value, for every boundary event.
  - In saturate mode with en held, tc pulses on every step attempted at the boundary.
- ovf:
  - Set on any boundary event; stays set until ovf_clr.
  - ovf_clr has lower priority than set: if both occur in the same cycle, ovf = 1.
- Arithmetic is WIDTH-bit unsigned; no intermediate overflow reaches counter.
- limit = 0: up wraps 0->0 and down wraps 0->0. Each step is a boundary event (tc every step).
- Latency: one clk from input sample to counter/tc/ovf update.
- Inputs are assumed synchronous to clk.

Optional Feature:
- MARIAM_CNT_PRESCALE_EN defined:
  - Internal prescaler counts enabled cycles 0..PRESCALE-1.
  - A step occurs only on the enabled cycle where the prescaler = PRESCALE-1; the prescaler then returns to 0.
  - The prescaler holds when en = 0.
  - load clears the prescaler to 0.
- Undefined: a step occurs on every enabled cycle; no prescaler logic is synthesised.

Decomposition:
- Shared package mariam_cnt_pkg holds:
  - DIR_UP = 1'b0, DIR_DOWN = 1'b1
  - MODE_WRAP = 1'b0, MODE_SAT = 1'b1
  - WIDTH legality limits
- Sub-module mariam_cnt_prescaler:
  - Parameter PRESCALE; inputs clk, reset_n, en, clr; output step_ok.
  - Instantiated only under MARIAM_CNT_PRESCALE_EN.

Test Plan (WIDTH = 4, macro undefined unless stated):
1. reset_n low mid-count (counter = 9) asynchronously -> counter = 0, tc = 0, ovf = 0 immediately, before the next clk edge.
2. limit = 9, wrap, up, en = 1 for 12 cycles from 0 -> sequence 1..9, 0, 1, 2; tc high only on the cycle counter = 0; ovf = 1 afterward.
3. limit = 5, saturate, down, load_val = 2, load then en for 4 cycles -> 2, 1, 0, 0, 0; tc pulses on both held-at-0 cycles.
4. load = 1 with load_val = 14, limit = 10, en = 1 -> counter = 10, tc = 0; load wins over the step.
5. ovf = 1, then ovf_clr asserted in the same cycle as a wrap event -> ovf stays 1; ovf_clr alone next cycle -> ovf = 0.
6. Macro defined, PRESCALE = 3, up, en = 1 -> counter increments every 3rd cycle; en low for 2 cycles pauses the prescaler phase; load resets the phase.
